// File: rtl/tqc_seq_pkg.sv
// Shared types and constants for the topological quantum controller command sequencer.
package tqc_seq_pkg;

   localparam int unsigned CMD_W = 8;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ISSUE   = 3'd1,
      WAIT    = 3'd2,
      RECOVER = 3'd3,
      REPORT  = 3'd4
   } seq_state_e;

   localparam logic [1:0] OP_BRAID = 2'b01;
   localparam logic [1:0] OP_CALIB = 2'b10;

   localparam logic [CMD_W-1:0] ST_BRAID_DONE = 8'h01;
   localparam logic [CMD_W-1:0] ST_CALIB_DONE = 8'h02;
   localparam logic [CMD_W-1:0] ST_ERROR      = 8'hFF;
   localparam logic [CMD_W-1:0] ST_TIMEOUT    = 8'hEE;
   localparam logic [CMD_W-1:0] CMD_CLEAR     = 8'h00;

endpackage

// File: rtl/tqc_cmd_fifo.sv
// Synchronous command buffer with registered count, full and empty flags.
module tqc_cmd_fifo
   import tqc_seq_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = CMD_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] head_c,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             push_en;
   logic             pop_en;

   // Push is refused while full even if a pop happens in the same cycle.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      push_en  = push && !full_q;
      pop_en   = pop && !empty_q;
      if (push_en) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop_en) begin
         rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({push_en, pop_en})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      full_d  = (count_d == CNT_FULL);
      empty_d = (count_d == '0);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   assign head_c = mem_q[rd_ptr_q];
   assign full   = full_q;
   assign empty  = empty_q;

endmodule

// File: rtl/tqc_cmd_sequencer.sv
// Issues buffered host commands to the controller one at a time, waits for status,
// clears controller errors/timeouts and returns one result per command.
module tqc_cmd_sequencer
   import tqc_seq_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 8192
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] host_cmd,
   input  logic       host_cmd_valid,
   output logic       host_cmd_ready,
   output logic [7:0] cmd_out,
   output logic       cmd_valid,
   input  logic [7:0] ctl_status,
   input  logic       ctl_status_valid,
   output logic [7:0] rsp_cmd,
   output logic [7:0] rsp_status,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic       seq_busy
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   seq_state_e       state_q, state_d;
   logic [CMD_W-1:0] cmd_out_q, cmd_out_d;
   logic             cmd_valid_q, cmd_valid_d;
   logic [CMD_W-1:0] rsp_cmd_q, rsp_cmd_d;
   logic [CMD_W-1:0] rsp_status_q, rsp_status_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             seq_busy_q, seq_busy_d;
   logic [CMD_W-1:0] snap_q, snap_d;
   logic             prev_valid_q, prev_valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             detect;
   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CMD_W-1:0] fifo_head;

   tqc_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (CMD_W)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (host_cmd_valid),
      .pop     (fifo_pop),
      .wdata   (host_cmd),
      .head_c  (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Outputs are registered, so each pulse is requested in the cycle before it shows.
   always_comb begin
      state_d      = state_q;
      cmd_out_d    = CMD_CLEAR;
      cmd_valid_d  = 1'b0;
      rsp_cmd_d    = rsp_cmd_q;
      rsp_status_d = rsp_status_q;
      rsp_valid_d  = rsp_valid_q;
      snap_d       = snap_q;
      cnt_d        = cnt_q;
      fifo_pop     = 1'b0;
      prev_valid_d = ctl_status_valid;
      detect       = ctl_status_valid && (!prev_valid_q || (ctl_status != snap_q));

      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               state_d     = ISSUE;
               cmd_valid_d = 1'b1;
               cmd_out_d   = fifo_head;
            end
         end
         ISSUE: begin
            fifo_pop  = 1'b1;
            rsp_cmd_d = fifo_head;
            snap_d    = ctl_status;
            cnt_d     = '0;
            state_d   = WAIT;
         end
         WAIT: begin
            // Detection takes priority over a coincident timeout.
            if (detect) begin
               rsp_status_d = ctl_status;
               if (ctl_status == ST_ERROR) begin
                  state_d     = RECOVER;
                  cmd_valid_d = 1'b1;
               end else begin
                  state_d     = REPORT;
                  rsp_valid_d = 1'b1;
               end
            end else if (cnt_q >= CNT_LAST) begin
               rsp_status_d = ST_TIMEOUT;
               state_d      = RECOVER;
               cmd_valid_d  = 1'b1;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RECOVER: begin
            state_d     = REPORT;
            rsp_valid_d = 1'b1;
         end
         REPORT: begin
            if (rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
            end
         end
         default: begin
            state_d     = IDLE;
            rsp_valid_d = 1'b0;
         end
      endcase

      seq_busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         cmd_out_q    <= CMD_CLEAR;
         cmd_valid_q  <= 1'b0;
         rsp_cmd_q    <= '0;
         rsp_status_q <= '0;
         rsp_valid_q  <= 1'b0;
         seq_busy_q   <= 1'b0;
         snap_q       <= '0;
         prev_valid_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         cmd_out_q    <= cmd_out_d;
         cmd_valid_q  <= cmd_valid_d;
         rsp_cmd_q    <= rsp_cmd_d;
         rsp_status_q <= rsp_status_d;
         rsp_valid_q  <= rsp_valid_d;
         seq_busy_q   <= seq_busy_d;
         snap_q       <= snap_d;
         prev_valid_q <= prev_valid_d;
         cnt_q        <= cnt_d;
      end
   end

   assign host_cmd_ready = !fifo_full;
   assign cmd_out        = cmd_out_q;
   assign cmd_valid      = cmd_valid_q;
   assign rsp_cmd        = rsp_cmd_q;
   assign rsp_status     = rsp_status_q;
   assign rsp_valid      = rsp_valid_q;
   assign seq_busy       = seq_busy_q;

endmodule
